// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline slice: ALU operation codes and
// the operand-forwarding source select.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b1001;
    localparam logic [3:0] ALU_LT  = 4'b1011;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_JAL = 4'b1110;
    localparam logic [3:0] ALU_GE  = 4'b1111;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Selects the freshest value for one source operand from EX/MEM, MEM/WB or
// the stage register; x0 is never forwarded and EX/MEM wins over MEM/WB.
module forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
    input  logic [DATA_WIDTH-1:0]     rs_data_i,
    input  logic                      exmem_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
    input  logic [DATA_WIDTH-1:0]     exmem_result_i,
    input  logic                      memwb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
    input  logic [DATA_WIDTH-1:0]     memwb_result_i,
    output logic [DATA_WIDTH-1:0]     fwd_data_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_data_o = rs_data_i;
        case (sel)
            FWD_EXMEM: fwd_data_o = exmem_result_i;
            FWD_MEMWB: fwd_data_o = memwb_result_i;
            default:   fwd_data_o = rs_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall/load-use bubble insertion and
// combinational operand forwarding into the ALU source muxes.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_alu_src_imm,
    input  logic                      id_src_a_pc,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      exmem_reg_write,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      load_use_hazard
);

    logic                      valid_q, valid_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_read_q, mem_read_d;
    logic                      mem_write_q, mem_write_d;
    logic [OPCODE_LENGTH-1:0]  alu_op_q, alu_op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic                      alu_src_imm_q, alu_src_imm_d;
    logic                      src_a_pc_q, src_a_pc_d;
    logic [DATA_WIDTH-1:0]     rs1_fwd, rs2_fwd;

    assign load_use_hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                             ((rd_q == id_rs1) || (rd_q == id_rs2));

    always_comb begin
        valid_d       = valid_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        alu_op_d      = alu_op_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        alu_src_imm_d = alu_src_imm_q;
        src_a_pc_d    = src_a_pc_q;
        // A bubble clears only control state; operand registers keep their contents.
        if (flush || (!stall && (load_use_hazard || !id_valid))) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            alu_op_d    = OPCODE_LENGTH'(ALU_AND);
            rd_d        = '0;
        end else if (!stall) begin
            valid_d       = 1'b1;
            reg_write_d   = id_reg_write;
            mem_read_d    = id_mem_read;
            mem_write_d   = id_mem_write;
            alu_op_d      = id_alu_op;
            rd_d          = id_rd;
            rs1_d         = id_rs1;
            rs2_d         = id_rs2;
            pc_d          = id_pc;
            rs1_data_d    = id_rs1_data;
            rs2_data_d    = id_rs2_data;
            imm_d         = id_imm;
            alu_src_imm_d = id_alu_src_imm;
            src_a_pc_d    = id_src_a_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            alu_op_q      <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            alu_src_imm_q <= 1'b0;
            src_a_pc_q    <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            alu_op_q      <= alu_op_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            alu_src_imm_q <= alu_src_imm_d;
            src_a_pc_q    <= src_a_pc_d;
        end
    end

    forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
        .rs_addr_i         (rs1_q),
        .rs_data_i         (rs1_data_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_result_i    (memwb_result),
        .fwd_data_o        (rs1_fwd)
    );

    forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
        .rs_addr_i         (rs2_q),
        .rs_data_i         (rs2_data_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_result_i    (memwb_result),
        .fwd_data_o        (rs2_fwd)
    );

    assign SrcA          = src_a_pc_q ? pc_q : rs1_fwd;
    assign SrcB          = alu_src_imm_q ? imm_q : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign Operation     = alu_op_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_rd         = rd_q;
    assign ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour
// plus hand sequences for load-use, stall/flush and reset corner cases.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm, id_src_a_pc, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] SrcA, SrcB, ex_pc, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic        load_use_hazard;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src_imm(id_alu_src_imm), .id_src_a_pc(id_src_a_pc), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .load_use_hazard(load_use_hazard)
    );

    typedef struct {
        logic        v, st, fl;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  r1, r2, rd;
        logic [3:0]  op;
        logic        asi, sapc, rw, mr, mw;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] e_a, e_b, e_pc, e_st;
        logic [3:0]  e_op;
        logic        e_v, e_rw, e_mw;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tv [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; stall = 0; flush = 0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0;
        id_alu_src_imm = 0; id_src_a_pc = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t);
        id_valid = t.v; stall = t.st; flush = t.fl;
        id_pc = t.pc; id_rs1_data = t.d1; id_rs2_data = t.d2; id_imm = t.imm;
        id_rs1 = t.r1; id_rs2 = t.r2; id_rd = t.rd; id_alu_op = t.op;
        id_alu_src_imm = t.asi; id_src_a_pc = t.sapc;
        id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
        exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
        memwb_reg_write = t.ww; memwb_rd = t.wrd; memwb_result = t.wres;
    endtask

    initial begin
        // Field order: v st fl pc d1 d2 imm r1 r2 rd op asi sapc rw mr mw
        //              xw xrd xres ww wrd wres | e_a e_b e_pc e_st e_op e_v e_rw e_mw e_rd
        tv[0]  = '{1,0,0, 'h0,  'h10,'h20,'h0,        5,6,1, 4'b0010, 0,0,1,0,0, 0,0,'h0,  0,0,'h0,
                   'h10, 'h20, 'h0, 'h20, 4'b0010, 1,1,0, 1};
        tv[1]  = '{1,0,0, 'h0,  'h10,'h20,'h0,        5,6,1, 4'b0010, 0,0,1,0,0, 1,5,'hAA, 1,5,'hBB,
                   'hAA, 'h20, 'h0, 'h20, 4'b0010, 1,1,0, 1};
        tv[2]  = '{1,0,0, 'h0,  'h10,'h20,'h0,        5,6,1, 4'b0010, 0,0,1,0,0, 1,0,'hAA, 1,5,'hBB,
                   'hBB, 'h20, 'h0, 'h20, 4'b0010, 1,1,0, 1};
        tv[3]  = '{1,0,0, 'h4,  'h10,'h20,'hFFFFFFFC, 5,6,2, 4'b0010, 1,0,1,0,0, 1,6,'h55, 0,0,'h0,
                   'h10, 'hFFFFFFFC, 'h4, 'h55, 4'b0010, 1,1,0, 2};
        tv[4]  = '{1,0,0, 'h100,'h10,'h20,'h0,        5,6,1, 4'b1110, 0,1,1,0,0, 0,0,'h0,  0,0,'h0,
                   'h100, 'h20, 'h100, 'h20, 4'b1110, 1,1,0, 1};
        tv[5]  = '{0,0,0, 'h100,'h10,'h20,'h0,        5,6,1, 4'b1110, 0,1,1,0,0, 0,0,'h0,  0,0,'h0,
                   'h100, 'h20, 'h100, 'h20, 4'b0000, 0,0,0, 0};
        tv[6]  = '{1,0,0, 'h8,  'h7, 'h20,'h0,        0,6,3, 4'b0001, 0,0,1,0,0, 1,0,'h99, 1,0,'h98,
                   'h7, 'h20, 'h8, 'h20, 4'b0001, 1,1,0, 3};
        tv[7]  = '{1,0,0, 'h40, 'h10,'h20,'h0,        5,6,4, 4'b0000, 0,0,1,0,0, 0,5,'hAA, 1,5,'hBB,
                   'hBB, 'h20, 'h40, 'h20, 4'b0000, 1,1,0, 4};
        tv[8]  = '{1,0,1, 'h40, 'h10,'h20,'h0,        5,6,4, 4'b0000, 0,0,1,0,0, 0,5,'hAA, 1,5,'hBB,
                   'hBB, 'h20, 'h40, 'h20, 4'b0000, 0,0,0, 0};
        tv[9]  = '{1,0,0, 'h44, 'h5, 'h9, 'h0,        3,4,0, 4'b0011, 0,0,0,0,1, 0,0,'h0,  0,0,'h0,
                   'h5, 'h9, 'h44, 'h9, 4'b0011, 1,0,1, 0};
        tv[10] = '{1,0,0, 'h48, 'h5, 'h9, 'h0,        3,4,5, 4'b1101, 0,0,1,0,0, 0,4,'hAA, 1,4,'h1234,
                   'h5, 'h1234, 'h48, 'h1234, 4'b1101, 1,1,0, 5};

        clear_inputs();
        reset = 0;
        step();
        step();
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_op", 32'(Operation), 0);
        check("rst_rd", 32'(ex_rd), 0);
        check("rst_pc", ex_pc, 0);
        check("rst_srca", SrcA, 0);
        check("rst_srcb", SrcB, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        check("rst_hazard", 32'(load_use_hazard), 0);
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 11; i++) begin
            apply(tv[i]);
            step();
            check($sformatf("v%0d_srca", i), SrcA, tv[i].e_a);
            check($sformatf("v%0d_srcb", i), SrcB, tv[i].e_b);
            check($sformatf("v%0d_pc", i), ex_pc, tv[i].e_pc);
            check($sformatf("v%0d_store", i), ex_store_data, tv[i].e_st);
            check($sformatf("v%0d_op", i), 32'(Operation), 32'(tv[i].e_op));
            check($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(tv[i].e_v));
            check($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(tv[i].e_rw));
            check($sformatf("v%0d_mw", i), 32'(ex_mem_write), 32'(tv[i].e_mw));
            check($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(tv[i].e_rd));
            check($sformatf("v%0d_hazard", i), 32'(load_use_hazard), 0);
        end

        // Load-use: LW x7 in EX, consumer of x7 in ID
        clear_inputs();
        id_valid = 1; id_rd = 7; id_rs1 = 2; id_mem_read = 1; id_reg_write = 1;
        id_alu_op = 4'b0010; id_alu_src_imm = 1;
        step();
        check("lw_mem_read", 32'(ex_mem_read), 1);
        id_mem_read = 0; id_rs1 = 1; id_rs2 = 7; id_rd = 8; id_alu_src_imm = 0;
        #1;
        check("lu_hazard", 32'(load_use_hazard), 1);
        step();
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_op", 32'(Operation), 0);
        check("lu_bubble_rd", 32'(ex_rd), 0);
        check("lu_hazard_clear", 32'(load_use_hazard), 0);
        step();
        check("lu_resume_rd", 32'(ex_rd), 8);
        clear_inputs();
        id_valid = 1; id_rd = 0; id_mem_read = 1; id_reg_write = 1; id_rs1 = 3;
        step();
        check("lw_x0_valid", 32'(ex_valid), 1);
        id_mem_read = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 4;
        #1;
        check("lw_x0_no_hazard", 32'(load_use_hazard), 0);

        // Stall holds the stage; forwarding still tracks MEM/WB
        clear_inputs();
        id_valid = 1; id_pc = 'h60; id_rs1_data = 'h11; id_rs2_data = 'h33;
        id_rs1 = 2; id_rs2 = 9; id_rd = 3; id_alu_op = 4'b0010; id_reg_write = 1;
        step();
        check("stall_pre_srcb", SrcB, 'h33);
        stall = 1; id_rd = 12; id_alu_op = 4'b0011; id_rs2_data = 'h44; id_pc = 'h64;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                memwb_reg_write = 1; memwb_rd = 9; memwb_result = 'h77;
            end
            step();
            check($sformatf("stall%0d_rd", c), 32'(ex_rd), 3);
            check($sformatf("stall%0d_op", c), 32'(Operation), 32'(4'b0010));
            check($sformatf("stall%0d_valid", c), 32'(ex_valid), 1);
            check($sformatf("stall%0d_pc", c), ex_pc, 'h60);
            check($sformatf("stall%0d_srcb", c), SrcB, (c >= 1) ? 32'h77 : 32'h33);
        end
        flush = 1;
        step();
        check("flush_stall_valid", 32'(ex_valid), 0);
        check("flush_stall_op", 32'(Operation), 0);
        check("flush_stall_rd", 32'(ex_rd), 0);

        // Reset mid-stall discards a held store immediately
        clear_inputs();
        id_valid = 1; id_mem_write = 1; id_rs1 = 1; id_rs2 = 2; id_rs2_data = 'h5;
        id_alu_op = 4'b0010;
        step();
        stall = 1;
        step();
        check("sw_held_valid", 32'(ex_valid), 1);
        check("sw_held_mw", 32'(ex_mem_write), 1);
        #2;
        reset = 0;
        #1;
        check("rst_async_valid", 32'(ex_valid), 0);
        check("rst_async_mw", 32'(ex_mem_write), 0);
        @(negedge clk);
        clear_inputs();
        reset = 1;
        id_valid = 1; id_rd = 9; id_rs1 = 3; id_rs1_data = 'h21; id_alu_op = 4'b0001;
        step();
        check("post_rst_valid", 32'(ex_valid), 1);
        check("post_rst_rd", 32'(ex_rd), 9);
        check("post_rst_srca", SrcA, 'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, operand width; OPCODE_LENGTH, 4, ALU operation code width; REG_ADDR_WIDTH, 5, register index width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state rising-edge.
  reset  in  1  asynchronous, active-low reset.
  id_valid  in  1  decode stage holds a real instruction.
  stall  in  1  hold all stage registers (downstream wait).
  flush  in  1  replace stage contents with a bubble (branch/jump redirect).
  id_pc, id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH  decoded operands.
  id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register indices.
  id_alu_op  in  OPCODE_LENGTH  ALU operation code.
  id_alu_src_imm, id_src_a_pc, id_reg_write, id_mem_read, id_mem_write  in  1  decoded controls.
  exmem_reg_write, memwb_reg_write  in  1  later-stage write enables.
  exmem_rd, memwb_rd  in  REG_ADDR_WIDTH  later-stage destinations.
  exmem_result, memwb_result  in  DATA_WIDTH  later-stage results.
  SrcA, SrcB  out  DATA_WIDTH  ALU operands.
  Operation  out  OPCODE_LENGTH  ALU operation code.
  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls.
  ex_rd  out  REG_ADDR_WIDTH  registered destination.
  ex_pc, ex_store_data  out  DATA_WIDTH  registered PC; forwarded rs2 for stores.
  load_use_hazard  out  1  combinational request for upstream to hold decode.

Function
REQ-003 Per rising edge, update priority SHALL be: flush > stall > load_use_hazard > normal load.
REQ-004 flush=1 SHALL load a bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0, Operation = 4'b0000, ex_rd = 0; data registers unchanged.
REQ-005 stall=1 with flush=0 SHALL hold every register unchanged.
REQ-006 load_use_hazard SHALL equal ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-007 load_use_hazard=1 with stall=0, flush=0 SHALL load a bubble (REQ-004) and hold the pipelined load in no other way.
REQ-008 Normal load SHALL capture all id_* inputs; id_valid=0 SHALL capture a bubble.
REQ-009 Latency id_* to registered outputs SHALL be exactly one cycle.
REQ-010 Forwarded rs1/rs2 SHALL be chosen combinationally: exmem_result if exmem_reg_write & exmem_rd != 0 & exmem_rd == reg index; else memwb_result under the same rule for MEM/WB; else registered rs data.
REQ-011 EX/MEM SHALL take priority over MEM/WB when both match; index 0 SHALL never be forwarded.
REQ-012 SrcA SHALL be ex_pc when registered src_a_pc=1, else forwarded rs1.
REQ-013 SrcB SHALL be registered imm when alu_src_imm=1, else forwarded rs2.
REQ-014 ex_store_data SHALL be forwarded rs2 regardless of alu_src_imm.
REQ-015 Forwarding SHALL apply while stalled, so held operands track later-stage results.

Reset
REQ-016 reset=0 SHALL asynchronously clear all registers to 0; outputs then: ex_valid=0, all controls 0, Operation=4'b0000, ex_rd=0, ex_pc=0, SrcA=SrcB=ex_store_data=0 (absent forwarding), load_use_hazard=0.
REQ-017 Reset release SHALL take effect at the next rising edge with no extra bubble cycles.
REQ-018 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction.

Structure
REQ-019 A shared package SHALL hold ALU operation code constants (AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, SRA 0111, EQ 1000, NE 1001, LT 1011, XOR 1101, JAL 1110, GE 1111) and a forwarding-select enum (FWD_REG, FWD_EXMEM, FWD_MEMWB).
REQ-020 Forwarding selection SHALL live in one sub-module, forward_unit, instantiated once per source operand.

Verification
REQ-021 Load ADD rs1=x5 (0x10), rs2=x6 (0x20) -> next cycle SrcA=0x10, SrcB=0x20, Operation=0010, ex_valid=1.
REQ-022 exmem_rd=5, exmem_result=0xAA, memwb_rd=5, memwb_result=0xBB, both write -> SrcA=0xAA; exmem_rd=0 same case -> SrcA=0xBB.
REQ-023 ex holds LW to x7; id uses rs2=x7 -> load_use_hazard=1, next cycle ex_valid=0, Operation=0000; id rs2=x0 with ex_rd=0 -> no hazard.
REQ-024 flush and stall both 1 -> bubble loaded; stall alone 3 cycles -> outputs constant, SrcB updates when memwb_result changes.
REQ-025 Assert reset mid-stall with valid SW held -> ex_valid=0, ex_mem_write=0 immediately, before any clock edge.
REQ-026 ADDI imm=0xFFFFFFFC, alu_src_imm=1, rs2 forwarded 0x55 -> SrcB=0xFFFFFFFC, ex_store_data=0x55.
